hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
- Parametrised RAW hazard detector for the ARM pipeline decode stage.
- Holds an internal shadow pipeline of in-flight destination registers, one slot per stage between ID and WB. Slots are updated from the ID-stage instruction each cycle.
- Compares every enabled ID source against the in-flight slots and raises a stall.
- Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_ADDR_W, 4, register-address width (16 ARM registers).
- NUM_SRC, 3, number of ID source operands checked (Rn, Rm, Rs).
- PIPE_DEPTH, 2, number of tracked in-flight slots (slot0 = EXE, slot1 = MEM, ...). Range 1..7.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_src  input  NUM_SRC*REG_ADDR_W  packed source register numbers; source i at bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_src_en  input  NUM_SRC  per-source "operand is read" flag (replaces two_src).
- id_dest  input  REG_ADDR_W  ID destination register.
- id_wb_en  input  1  ID instruction writes id_dest.
- id_is_load  input  1  ID instruction is LDR (result available only after MEM).
- flush  input  1  branch taken; the ID instruction is squashed.
- freeze  input  1  global pipeline hold (e.g. memory wait).
- cnt_clr  input  1  synchronous clear of stall counter.
- hazard_detected  output  1  stall IF/ID this cycle; combinational.
- fwd_sel  output  NUM_SRC*3  per-source forwarding select, 3 bits each. 0 = register file; k = slot k-1. Constant 0 unless FORWARDING_EN.
- stall_cnt  output  CNT_W  registered saturating count of stalled cycles.

Behaviour:
- Reset (rst_n low, async):
  - all slots: valid=0, wb=0, load=0, dest=0;
  - stall_cnt = 0;
  - hazard_detected = 0 and fwd_sel = 0 as a consequence of the empty slots.
- Slot k is "live" iff valid & wb.
- Source i "matches" slot k iff id_valid & id_src_en[i] & live(k) & src_i == dest(k).
- Hazard, without FORWARDING_EN:
  - hazard_detected = OR of all matches, over all sources and slots;
  - forced 0 when flush=1 or id_valid=0.
- Slot update on each rising clk:
  - freeze=1: all slots and stall_cnt hold; this takes precedence over every other input.
  - Otherwise, slot[k] <= slot[k-1] for k >= 1.
  - slot0 <= {valid=1, dest=id_dest, wb=id_wb_en, load=id_is_load} when id_valid & !flush & !hazard_detected.
  - Otherwise slot0 <= bubble (all zero). A hazard therefore inserts exactly one bubble per stall cycle; the oldest slot falls off the end.
- Stall latency: a dependency on slot k stalls for PIPE_DEPTH-k cycles.
  - Example with PIPE_DEPTH=2: back-to-back dependency = 2 stall cycles; one instruction gap = 1 cycle.
- Writes with id_wb_en=0 never create a hazard, even if id_dest matches.
- R15 receives no special treatment; decode gates it via id_src_en.
- Simultaneous flush and hazard: flush wins. hazard_detected = 0 and a bubble is inserted.
- stall_cnt:
  - when !freeze: +1 on each cycle with hazard_detected=1;
  - saturates at all-ones; no wrap;
  - cnt_clr has priority over increment and works even when freeze=1.
- Reset mid-stall: the slots empty immediately and hazard deasserts asynchronously.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined:
  - a match only causes a hazard when it is on slot0 with load=1 (load-use); hazard is then 1 cycle;
  - all other matches produce forwarding instead;
  - fwd_sel[i] = k+1 for the lowest-index (youngest) matching slot k, excluding a load-pending slot0;
  - fwd_sel[i] = 0 if there is no match or the source is disabled.
- Not defined:
  - full-stall behaviour as above;
  - fwd_sel tied to 0;
  - the load bit is still stored but unused.

Test Plan:
- Reset then idle: rst_n=0 with id_valid=1, src0=3 -> hazard=0, stall_cnt=0, fwd_sel=0.
- Back-to-back RAW, PIPE_DEPTH=2, no forwarding:
  - ADD dest=R2 wb=1, then src0=R2 en=1 -> hazard=1 for exactly 2 cycles, stall_cnt=2;
  - the dependent instruction enters slot0 on the 3rd cycle.
- Disabled source / no writeback:
  - src1=R5 with id_src_en[1]=0 against live R5 -> hazard=0;
  - dest R5 with wb=0 followed by a read of R5 -> hazard=0.
- Flush and freeze:
  - hazard pending plus flush=1 -> hazard=0 and slot0 gets a bubble;
  - freeze=1 for 3 cycles during a stall -> slots hold, stall_cnt unchanged, hazard stays 1.
- Counter saturation, CNT_W=4: 20 stall cycles -> stall_cnt=15; cnt_clr=1 -> 0 next cycle.
- With HAZARD_FORWARDING_EN:
  - LDR R1 then src0=R1 -> hazard=1 for 1 cycle, then fwd_sel[0]=2;
  - ADD R1 then src0=R1 -> hazard=0, fwd_sel[0]=1;
  - R1 written in both slots -> fwd_sel=1 (youngest wins).

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// RAW hazard detector for the decode stage, with a shadow pipeline of in-flight destinations.
// Latency: hazard_detected/fwd_sel are combinational from ID inputs and slot state; slots and counter update on the clock edge.
// Backpressure: freeze holds all state; a detected hazard stalls ID and pushes one bubble per stall cycle.
//
// Optional feature macro: HAZARD_FORWARDING_EN
//   undefined : every live RAW match stalls until the producer leaves the tracked slots; fwd_sel = 0.
//   defined   : only a load-use match on slot0 stalls (one cycle); other matches forward via fwd_sel.
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   id_valid, id_src, id_src_en ID instruction and its per-source read enables
//   id_dest, id_wb_en, id_is_load ID destination, write-back flag, load flag
//   flush, freeze, cnt_clr     squash ID, global hold, synchronous stall-counter clear
//   hazard_detected            stall IF/ID this cycle
//   fwd_sel                    3 bits per source: 0 = register file, k = slot k-1
//   stall_cnt                  saturating count of stalled cycles
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_en,
    input  logic [REG_ADDR_W-1:0]         id_dest,
    input  logic                          id_wb_en,
    input  logic                          id_is_load,
    input  logic                          flush,
    input  logic                          freeze,
    input  logic                          cnt_clr,
    output logic                          hazard_detected,
    output logic [NUM_SRC*3-1:0]          fwd_sel,
    output logic [CNT_W-1:0]              stall_cnt
);

    typedef struct packed {
        logic                  vld;
        logic                  wb;
        logic                  ld;
        logic [REG_ADDR_W-1:0] dest;
    } slot_t;

    slot_t slots [PIPE_DEPTH];

    // match[i][k]: source i reads the register that slot k will write
    logic [NUM_SRC-1:0][PIPE_DEPTH-1:0] match;
    logic                               hazard_raw;
    logic                               issue;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                match[i][k] = id_valid && id_src_en[i] && slots[k].vld && slots[k].wb &&
                              (id_src[i*REG_ADDR_W +: REG_ADDR_W] == slots[k].dest);
            end
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // Only a load still in EXE cannot be forwarded; everything else is bypassed
    // from the youngest matching slot (scan oldest-first so the youngest wins).
    always_comb begin
        hazard_raw = 1'b0;
        fwd_sel    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hazard_raw = hazard_raw | (match[i][0] & slots[0].ld);
            for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
                if (match[i][k] && !(k == 0 && slots[0].ld)) begin
                    fwd_sel[i*3 +: 3] = 3'(k + 1);
                end
            end
        end
    end
`else
    logic [PIPE_DEPTH-1:0] load_bits_unused;

    always_comb begin
        hazard_raw = |match;
        fwd_sel    = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            load_bits_unused[k] = slots[k].ld;
        end
    end
`endif

    // A squashed instruction never stalls; flush wins over any match.
    assign hazard_detected = hazard_raw & id_valid & ~flush;
    assign issue           = id_valid & ~flush & ~hazard_detected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else if (!freeze) begin
            for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
                slots[k] <= slots[k-1];
            end
            if (issue) begin
                slots[0] <= '{vld: 1'b1, wb: id_wb_en, ld: id_is_load, dest: id_dest};
            end else begin
                slots[0] <= '0;
            end
        end
    end

    // Clear beats increment and is honoured even while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (!freeze && hazard_detected && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed, table-driven bench for hazard_scoreboard_unit (PIPE_DEPTH=2).
// Instance a uses CNT_W=16 for the functional table; instance b uses CNT_W=4 for saturation.
// Both builds of HAZARD_FORWARDING_EN are covered with separate expectation tables.
module tb_hazard_scoreboard_unit;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [11:0] id_src;
    logic [2:0]  id_src_en;
    logic [3:0]  id_dest;
    logic        id_wb_en;
    logic        id_is_load;
    logic        flush;
    logic        freeze;
    logic        cnt_clr;

    logic        haz_a, haz_b;
    logic [8:0]  fwd_a, fwd_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.REG_ADDR_W(4), .NUM_SRC(3), .PIPE_DEPTH(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_en(id_src_en),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_is_load(id_is_load), .flush(flush),
        .freeze(freeze), .cnt_clr(cnt_clr), .hazard_detected(haz_a), .fwd_sel(fwd_a),
        .stall_cnt(cnt_a)
    );

    hazard_scoreboard_unit #(.REG_ADDR_W(4), .NUM_SRC(3), .PIPE_DEPTH(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_en(id_src_en),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_is_load(id_is_load), .flush(flush),
        .freeze(freeze), .cnt_clr(cnt_clr), .hazard_detected(haz_b), .fwd_sel(fwd_b),
        .stall_cnt(cnt_b)
    );

    typedef struct {
        logic        v;
        logic [11:0] src;
        logic [2:0]  en;
        logic [3:0]  dest;
        logic        wb, ld, fl, fz, clr;
        logic        exp_haz;
        logic [8:0]  exp_fwd;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [2:0] en, input logic [3:0] dest,
                                input logic wb, input logic ld, input logic fl, input logic fz,
                                input logic clr, input logic eh, input logic [8:0] ef,
                                input logic [15:0] ec);
        vec_t r;
        r.v = v; r.src = {s2, s1, s0}; r.en = en; r.dest = dest;
        r.wb = wb; r.ld = ld; r.fl = fl; r.fz = fz; r.clr = clr;
        r.exp_haz = eh; r.exp_fwd = ef; r.exp_cnt = ec;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        id_valid   = v.v;
        id_src     = v.src;
        id_src_en  = v.en;
        id_dest    = v.dest;
        id_wb_en   = v.wb;
        id_is_load = v.ld;
        flush      = v.fl;
        freeze     = v.fz;
        cnt_clr    = v.clr;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a live-looking ID instruction: outputs must stay quiet.
        rst_n = 1'b0;
        drive(mk(1, 3, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        chk("reset_hazard", 32'(haz_a), 32'd0);
        chk("reset_fwd", 32'(fwd_a), 32'd0);
        chk("reset_cnt", 32'(cnt_a), 32'd0);
        chk("reset_cnt_b", 32'(cnt_b), 32'd0);
        drive(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        tick();

`ifndef HAZARD_FORWARDING_EN
        // back-to-back RAW: 2 stall cycles, dependent R4 issues on the 3rd
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 3'b001, 4, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 3'b001, 4, 1, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 2, 0, 0, 3'b001, 4, 1, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 4, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        // one-instruction gap: 1 stall cycle
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 6, 1, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 6, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 3));
        tbl.push_back(mk(1, 6, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        // disabled source ignored; enabled src1 on slot1 stalls
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 5, 1, 0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 0, 5, 0, 3'b101, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 0, 5, 0, 3'b010, 0, 0, 0, 0, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        // producer without write-back never hazards
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 5, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 5, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 5, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        // flush beats hazard; the flushed R8 writer must not reach slot0
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 7, 1, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 7, 0, 0, 3'b001, 8, 1, 0, 1, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 8, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        // freeze for 3 cycles mid-stall: state and counter hold
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 9, 1, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 9, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 5));
        tbl.push_back(mk(1, 9, 0, 0, 3'b001, 0, 0, 0, 0, 1, 0, 1, 0, 6));
        tbl.push_back(mk(1, 9, 0, 0, 3'b001, 0, 0, 0, 0, 1, 0, 1, 0, 6));
        tbl.push_back(mk(1, 9, 0, 0, 3'b001, 0, 0, 0, 0, 1, 0, 1, 0, 6));
        tbl.push_back(mk(1, 9, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 6));
        tbl.push_back(mk(1, 9, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        // clear works while frozen
        tbl.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1, 0, 0, 7));
        tbl.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // dependency through the third source
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3, 3'b100, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3, 3'b100, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 3, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0, 2));
`else
        // load-use: 1 stall, then forward from slot1
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 9'd2, 1));
        // ALU producer: no stall, forward from slot0
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 3'b001, 1, 1, 0, 0, 0, 0, 0, 9'd1, 1));
        // R1 in both slots: youngest wins
        tbl.push_back(mk(1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 9'd1, 1));
        // src1 forwarding lands in its own 3-bit field
        tbl.push_back(mk(1, 0, 1, 0, 3'b011, 0, 0, 0, 0, 0, 0, 0, 9'd16, 1));
        // flush on a load-use: no stall, bubble, then slot1 forward
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 3, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3, 0, 0, 3'b001, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 9'd2, 1));
`endif

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_hazard", i), 32'(haz_a), 32'(tbl[i].exp_haz));
            chk($sformatf("vec%0d_fwd", i), 32'(fwd_a), 32'(tbl[i].exp_fwd));
            chk($sformatf("vec%0d_cnt", i), 32'(cnt_a), 32'(tbl[i].exp_cnt));
            tick();
        end

        // Saturation on the 4-bit counter: 20 load-use rounds of 4 cycles each.
        drive(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tick();
        chk("sat_clear", 32'(cnt_b), 32'd0);
        for (int r = 0; r < 20; r++) begin
            drive(mk(1, 0, 0, 0, 3'b000, 2, 1, 1, 0, 0, 0, 0, 0, 0));
            tick();
            drive(mk(1, 2, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                if (r == 0) begin
                    if (j == 0) chk("sat_r0_haz0", 32'(haz_b), 32'd1);
                    if (j == 1) chk("sat_r0_haz1", 32'(haz_b), FWD ? 32'd0 : 32'd1);
                    if (j == 1) chk("sat_r0_fwd1", 32'(fwd_b), FWD ? 32'd2 : 32'd0);
                    if (j == 2) chk("sat_r0_haz2", 32'(haz_b), 32'd0);
                end
                tick();
            end
            if (r == 0) chk("sat_round0_cnt", 32'(cnt_b), FWD ? 32'd1 : 32'd2);
        end
        chk("sat_cnt", 32'(cnt_b), 32'd15);
        drive(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tick();
        chk("sat_clr_frozen", 32'(cnt_b), 32'd0);

        // Reset mid-stall: hazard drops without waiting for a clock.
        drive(mk(1, 0, 0, 0, 3'b000, 2, 1, 1, 0, 0, 0, 0, 0, 0));
        tick();
        drive(mk(1, 2, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("pre_reset_haz", 32'(haz_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_haz", 32'(haz_a), 32'd0);
        chk("async_reset_cnt", 32'(cnt_a), 32'd0);
        #4;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
